// File: rtl/axis_channel_permute.sv
// rtl/axis_channel_permute.sv - AXI4-Stream pixel channel permuter with frame-synchronous map and 2-entry skid
// Output k takes input channel MAP[k]; out-of-range selects give zero. The map is latched on SOF beats only.
module axis_channel_permute #(
  parameter int CH_WIDTH = 8,
  parameter int NUM_CH   = 3,
  parameter int SEL_W    = 2,
  parameter logic [NUM_CH*SEL_W-1:0] DEFAULT_MAP = 6'h21
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [NUM_CH*SEL_W-1:0]      MAP_IN,
  input  logic                         BYPASS_IN,
  input  logic [NUM_CH*CH_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                         S_AXIS_TUSER,
  input  logic                         S_AXIS_TLAST,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  output logic [NUM_CH*CH_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                         M_AXIS_TUSER,
  output logic                         M_AXIS_TLAST,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic [NUM_CH*SEL_W-1:0]      MAP_ACTIVE,
  output logic                         BYPASS_ACTIVE
);

  localparam int DW = NUM_CH * CH_WIDTH;
  localparam int MW = NUM_CH * SEL_W;

  logic          r_ready;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_user;
  logic          r_last;
  logic          r_skid_valid;
  logic [DW-1:0] r_skid_data;
  logic          r_skid_user;
  logic          r_skid_last;
  logic [MW-1:0] r_map;
  logic          r_bypass;

  logic          w_accept;
  logic          w_main_free;
  logic          w_skid_next;
  logic [MW-1:0] w_map;
  logic          w_bypass;
  logic [DW-1:0] w_perm;

  assign w_accept    = S_AXIS_TVALID & r_ready;
  assign w_main_free = !r_valid || M_AXIS_TREADY;
  // A SOF beat is permuted with the map being latched alongside it.
  assign w_map       = S_AXIS_TUSER ? MAP_IN : r_map;
  assign w_bypass    = S_AXIS_TUSER ? BYPASS_IN : r_bypass;
  assign w_skid_next = w_main_free ? 1'b0 : (r_skid_valid | w_accept);

  always_comb begin
    w_perm = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (w_map[k*SEL_W +: SEL_W] == SEL_W'(j))
          w_perm[k*CH_WIDTH +: CH_WIDTH] = S_AXIS_TDATA[j*CH_WIDTH +: CH_WIDTH];
      end
    end
    if (w_bypass)
      w_perm = S_AXIS_TDATA;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ready      <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_user       <= 1'b0;
      r_last       <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_user  <= 1'b0;
      r_skid_last  <= 1'b0;
      r_map        <= DEFAULT_MAP;
      r_bypass     <= 1'b0;
    end else begin
      r_ready <= !w_skid_next;
      if (w_accept && S_AXIS_TUSER) begin
        r_map    <= MAP_IN;
        r_bypass <= BYPASS_IN;
      end
      if (w_main_free) begin
        // Skid full implies no accept this cycle, so draining it never races a new beat.
        if (r_skid_valid) begin
          r_data       <= r_skid_data;
          r_user       <= r_skid_user;
          r_last       <= r_skid_last;
          r_valid      <= 1'b1;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_data  <= w_perm;
          r_user  <= S_AXIS_TUSER;
          r_last  <= S_AXIS_TLAST;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid_data  <= w_perm;
        r_skid_user  <= S_AXIS_TUSER;
        r_skid_last  <= S_AXIS_TLAST;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign S_AXIS_TREADY = r_ready;
  assign M_AXIS_TVALID = r_valid;
  assign M_AXIS_TDATA  = r_data;
  assign M_AXIS_TUSER  = r_user;
  assign M_AXIS_TLAST  = r_last;
  assign MAP_ACTIVE    = r_map;
  assign BYPASS_ACTIVE = r_bypass;

endmodule

// File: tb/tb_axis_channel_permute.sv
// tb/tb_axis_channel_permute.sv - directed and scoreboard bench for axis_channel_permute
module tb_axis_channel_permute;

  logic        aclk;
  logic        arst;
  logic [5:0]  map_in;
  logic        byp_in;
  logic [23:0] s_data;
  logic        s_user;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] m_data;
  logic        m_user;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic [5:0]  map_act;
  logic        byp_act;

  int total = 0;
  int bad   = 0;

  axis_channel_permute #(
    .CH_WIDTH(8), .NUM_CH(3), .SEL_W(2), .DEFAULT_MAP(6'h21)
  ) dut (
    .ACLK(aclk), .ARESET(arst), .MAP_IN(map_in), .BYPASS_IN(byp_in),
    .S_AXIS_TDATA(s_data), .S_AXIS_TUSER(s_user), .S_AXIS_TLAST(s_last),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready),
    .M_AXIS_TDATA(m_data), .M_AXIS_TUSER(m_user), .M_AXIS_TLAST(m_last),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready),
    .MAP_ACTIVE(map_act), .BYPASS_ACTIVE(byp_act)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [23:0] f_perm(input logic [23:0] d, input logic [5:0] m, input logic b);
    logic [23:0] r;
    logic [1:0]  s;
    if (b) return d;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      s = m[2*k +: 2];
      case (s)
        2'd0:    r[8*k +: 8] = d[7:0];
        2'd1:    r[8*k +: 8] = d[15:8];
        2'd2:    r[8*k +: 8] = d[23:16];
        default: r[8*k +: 8] = 8'h00;
      endcase
    end
    return r;
  endfunction

  task idle();
    s_valid = 1'b0;
    s_user  = 1'b0;
    s_last  = 1'b0;
  endtask

  // Present one beat and pass the edge that accepts it; returns #1 after that edge.
  task send(input logic [23:0] d, input logic u, input logic l, input logic [5:0] m, input logic b);
    s_data = d; s_user = u; s_last = l; map_in = m; byp_in = b; s_valid = 1'b1;
    @(posedge aclk); #1;
  endtask

  task test_reset();
    arst = 1'b1; idle(); m_ready = 1'b0; map_in = 6'h00; byp_in = 1'b0; s_data = '0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%0h exp=0", m_valid); end
    total++; if (m_data !== 24'h0) begin bad++; $display("FAIL reset_tdata got=%06h exp=000000", m_data); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%0h exp=0", s_ready); end
    total++; if (map_act !== 6'h21) begin bad++; $display("FAIL reset_map got=%02h exp=21", map_act); end
    total++; if (byp_act !== 1'b0) begin bad++; $display("FAIL reset_bypass got=%0h exp=0", byp_act); end
    @(posedge aclk); #1;
    arst = 1'b0;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL release_tready_early got=%0h exp=0", s_ready); end
    @(posedge aclk); #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL release_tready got=%0h exp=1", s_ready); end
  endtask

  task test_basic();
    logic [23:0] din [4];
    logic [23:0] dexp [4];
    din[0] = 24'hAABBCC; dexp[0] = 24'hAACCBB;
    din[1] = 24'h112233; dexp[1] = 24'h113322;
    din[2] = 24'h445566; dexp[2] = 24'h446655;
    din[3] = 24'h778899; dexp[3] = 24'h779988;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL basic_tready beat=%0d got=%0h exp=1", i, s_ready); end
      send(din[i], (i == 0), (i == 3), 6'h21, 1'b0);
      total++;
      if (m_valid !== 1'b1 || m_data !== dexp[i] || m_user !== (i == 0) || m_last !== (i == 3)) begin
        bad++;
        $display("FAIL basic_beat%0d got v=%0h d=%06h u=%0h l=%0h exp v=1 d=%06h u=%0h l=%0h",
                 i, m_valid, m_data, m_user, m_last, dexp[i], (i == 0), (i == 3));
      end
    end
    idle();
    @(posedge aclk); #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0h exp=0", m_valid); end
  endtask

  task test_map_latch();
    m_ready = 1'b1;
    send(24'h112233, 1'b1, 1'b0, 6'h06, 1'b0);
    total++; if (m_data !== 24'h332211 || map_act !== 6'h06) begin bad++; $display("FAIL latch_sof got d=%06h map=%02h exp d=332211 map=06", m_data, map_act); end
    send(24'h112233, 1'b0, 1'b0, 6'h21, 1'b0);
    total++; if (m_data !== 24'h332211 || map_act !== 6'h06) begin bad++; $display("FAIL latch_mid1 got d=%06h map=%02h exp d=332211 map=06", m_data, map_act); end
    send(24'hAABBCC, 1'b0, 1'b1, 6'h21, 1'b0);
    total++; if (m_data !== 24'hCCBBAA || map_act !== 6'h06) begin bad++; $display("FAIL latch_mid2 got d=%06h map=%02h exp d=CCBBAA map=06", m_data, map_act); end
    send(24'hAABBCC, 1'b1, 1'b0, 6'h21, 1'b0);
    total++; if (m_data !== 24'hAACCBB || map_act !== 6'h21) begin bad++; $display("FAIL latch_next_sof got d=%06h map=%02h exp d=AACCBB map=21", m_data, map_act); end
    idle();
    @(posedge aclk); #1;
  endtask

  task test_backpressure();
    logic [23:0] src [3];
    logic [25:0] bexp [3];
    int tx;
    int rx;
    src[0] = 24'h010203; bexp[0] = {1'b1, 1'b0, 24'h010302};
    src[1] = 24'h040506; bexp[1] = {1'b0, 1'b0, 24'h040605};
    src[2] = 24'h070809; bexp[2] = {1'b0, 1'b1, 24'h070908};
    tx = 0; rx = 0;
    map_in = 6'h21; byp_in = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      s_valid = (tx < 3);
      if (tx < 3) begin
        s_data = src[tx]; s_user = (tx == 0); s_last = (tx == 2);
      end
      m_ready = (cyc >= 6);
      @(negedge aclk);
      if (cyc == 5) begin
        total++; if (tx !== 2) begin bad++; $display("FAIL bp_accepted got=%0d exp=2", tx); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_tready got=%0h exp=0", s_ready); end
        total++; if (m_valid !== 1'b1 || m_data !== 24'h010302) begin bad++; $display("FAIL bp_hold got v=%0h d=%06h exp v=1 d=010302", m_valid, m_data); end
      end
      if (m_valid && m_ready) begin
        total++;
        if (rx >= 3) begin
          bad++; $display("FAIL bp_extra_beat got d=%06h exp none", m_data);
        end else if ({m_user, m_last, m_data} !== bexp[rx]) begin
          bad++; $display("FAIL bp_order beat=%0d got=%07h exp=%07h", rx, {m_user, m_last, m_data}, bexp[rx]);
        end
        rx++;
      end
      if (s_valid && s_ready) tx++;
      @(posedge aclk); #1;
    end
    idle();
    total++; if (rx !== 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", rx); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0h exp=0", m_valid); end
  endtask

  task test_random();
    logic [25:0] q [$];
    logic [25:0] want;
    logic [25:0] prev;
    logic        prev_stall;
    logic [5:0]  amap;
    logic        abyp;
    logic        acc;
    logic [31:0] rnd;
    int          sent;
    amap = 6'h21; abyp = 1'b0; prev = '0; prev_stall = 1'b0; acc = 1'b0; sent = 0;
    idle();
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (sent >= 1000 && q.size() == 0) break;
      if (!s_valid || acc) begin
        s_valid = (sent < 1000) && ($urandom_range(3) != 0);
        rnd = $urandom;
        s_data = rnd[23:0];
        rnd = $urandom;
        map_in = rnd[5:0];
        byp_in = (rnd[10:8] == 3'd0);
        s_last = (rnd[14:12] == 3'd0);
        s_user = (sent == 0) || (rnd[19:16] == 4'd0);
      end
      m_ready = ($urandom_range(3) != 0);
      @(negedge aclk);
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || {m_user, m_last, m_data} !== prev) begin
          bad++; $display("FAIL rand_stable cyc=%0d got v=%0h %07h exp v=1 %07h", cyc, m_valid, {m_user, m_last, m_data}, prev);
        end
      end
      if (m_valid && m_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_extra cyc=%0d got=%07h exp none", cyc, {m_user, m_last, m_data});
        end else begin
          want = q.pop_front();
          if ({m_user, m_last, m_data} !== want) begin
            bad++; $display("FAIL rand_data cyc=%0d got=%07h exp=%07h", cyc, {m_user, m_last, m_data}, want);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev = {m_user, m_last, m_data};
      acc = s_valid && s_ready;
      if (acc) begin
        if (s_user) begin
          amap = map_in; abyp = byp_in;
        end
        q.push_back({s_user, s_last, f_perm(s_data, amap, abyp)});
        sent++;
      end
      @(posedge aclk); #1;
    end
    idle();
    total++; if (sent !== 1000) begin bad++; $display("FAIL rand_sent got=%0d exp=1000", sent); end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL rand_left got=%0d exp=0", q.size()); end
  endtask

  task test_out_of_range();
    m_ready = 1'b1;
    @(posedge aclk); #1;
    send(24'hFFFFFF, 1'b1, 1'b0, 6'h3F, 1'b0);
    total++; if (m_data !== 24'h000000 || map_act !== 6'h3F) begin bad++; $display("FAIL oor_zero got d=%06h map=%02h exp d=000000 map=3F", m_data, map_act); end
    send(24'h123456, 1'b1, 1'b0, 6'h3F, 1'b1);
    total++; if (m_data !== 24'h123456 || byp_act !== 1'b1) begin bad++; $display("FAIL oor_bypass got d=%06h byp=%0h exp d=123456 byp=1", m_data, byp_act); end
    send(24'h123456, 1'b1, 1'b1, 6'h00, 1'b0);
    total++; if (m_data !== 24'h565656 || byp_act !== 1'b0) begin bad++; $display("FAIL oor_broadcast got d=%06h byp=%0h exp d=565656 byp=0", m_data, byp_act); end
    idle();
    @(posedge aclk); #1;
  endtask

  task test_reset_midflight();
    logic seen;
    m_ready = 1'b0;
    send(24'h010203, 1'b1, 1'b0, 6'h06, 1'b0);
    send(24'h040506, 1'b0, 1'b0, 6'h06, 1'b0);
    idle();
    total++; if (s_ready !== 1'b0 || m_valid !== 1'b1 || map_act !== 6'h06) begin bad++; $display("FAIL mid_pre got rdy=%0h v=%0h map=%02h exp rdy=0 v=1 map=06", s_ready, m_valid, map_act); end
    #2 arst = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_async_tvalid got=%0h exp=0", m_valid); end
    total++; if (map_act !== 6'h21) begin bad++; $display("FAIL mid_async_map got=%02h exp=21", map_act); end
    @(posedge aclk); #1;
    arst = 1'b0; m_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (m_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_stale got=%0h exp=0", seen); end
    @(posedge aclk); #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0h exp=1", s_ready); end
    send(24'hAABBCC, 1'b1, 1'b1, 6'h21, 1'b0);
    idle();
    total++; if (m_valid !== 1'b1 || m_data !== 24'hAACCBB) begin bad++; $display("FAIL mid_resume got v=%0h d=%06h exp v=1 d=AACCBB", m_valid, m_data); end
    @(posedge aclk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_map_latch();
    test_backpressure();
    test_random();
    test_out_of_range();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_channel_permute.md
Name: axis_channel_permute

Overview:
- Parameterised AXI4-Stream video pixel channel permuter with a registered two-entry skid buffer.
- Generalises the fixed G/B swap: any number of channels, any channel width, and a runtime-selectable channel map.
- The map is frame-synchronous: it is latched only on start-of-frame beats, so it never changes mid-frame.
- Sits between a video source (VDMA/test-pattern) and the display pipeline. Outputs are fully registered, so it also serves as a timing break.

Parameters:
- CH_WIDTH, 8, bits per colour channel.
- NUM_CH, 3, channels per pixel. TDATA width = NUM_CH*CH_WIDTH; channel k occupies bits [k*CH_WIDTH +: CH_WIDTH].
- SEL_W, 2, width of one map select field; must satisfy 2**SEL_W >= NUM_CH.
- DEFAULT_MAP, 6'h21, active map after reset. Field k is at [k*SEL_W +: SEL_W]. 6'h21 gives out0=in1, out1=in0, out2=in2, which is the G/B swap.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset. One clock; reset is asynchronous and active-high.
- MAP_IN  in  NUM_CH*SEL_W  requested channel map. Field k selects the input channel driving output channel k.
- BYPASS_IN  in  1  1 = pass data unpermuted. Latched together with MAP_IN.
- S_AXIS_TDATA  in  NUM_CH*CH_WIDTH  input pixel.
- S_AXIS_TUSER  in  1  start of frame.
- S_AXIS_TLAST  in  1  end of line.
- S_AXIS_TVALID  in  1  input valid.
- S_AXIS_TREADY  out  1  input ready, registered.
- M_AXIS_TDATA  out  NUM_CH*CH_WIDTH  permuted pixel, registered.
- M_AXIS_TUSER  out  1  registered copy of TUSER.
- M_AXIS_TLAST  out  1  registered copy of TLAST.
- M_AXIS_TVALID  out  1  output valid, registered.
- M_AXIS_TREADY  in  1  output ready.
- MAP_ACTIVE  out  NUM_CH*SEL_W  currently applied map.
- BYPASS_ACTIVE  out  1  currently applied bypass.

Behaviour:
- Reset values, asserted asynchronously while ARESET=1:
  - M_AXIS_TVALID=0, M_AXIS_TDATA/TUSER/TLAST=0.
  - S_AXIS_TREADY=0; it rises on the first ACLK edge after ARESET deasserts.
  - MAP_ACTIVE=DEFAULT_MAP, BYPASS_ACTIVE=0.
  - Skid entry empty.
- Accept = S_AXIS_TVALID & S_AXIS_TREADY. Transfer out = M_AXIS_TVALID & M_AXIS_TREADY.
- Map latching:
  - On an accepted beat with S_AXIS_TUSER=1, MAP_IN/BYPASS_IN are captured into MAP_ACTIVE/BYPASS_ACTIVE on that edge.
  - The newly captured map is applied to that same SOF beat. The permute mux uses MAP_IN when the accepted beat has TUSER=1, otherwise MAP_ACTIVE.
  - MAP_IN changes on non-SOF beats have no effect.
- Permutation, purely combinational before the storage registers:
  - Output channel k = input channel MAP[k].
  - If MAP[k] >= NUM_CH, output channel k = 0.
  - Duplicate selects are legal; for example, map all-zeros broadcasts channel 0.
  - BYPASS=1: output = input unchanged.
  - TUSER and TLAST travel unmodified alongside the data.
- Buffering, two entries (main output register + one skid register):
  - Latency is 1 cycle: a beat accepted at edge n is on M_AXIS at edge n with TVALID=1, visible the following cycle.
  - Full throughput: one beat per cycle while M_AXIS_TREADY=1.
  - S_AXIS_TREADY = !skid_full, registered. When TREADY falls, at most one extra beat has been accepted, and it sits in the skid.
  - Accept while the main register is held (TVALID=1, TREADY=0) → beat goes to the skid; S_AXIS_TREADY drops next cycle.
  - Output transfer with skid full → skid moves to main; S_AXIS_TREADY rises next cycle.
  - Output transfer and accept on the same edge with skid empty → new beat goes directly to main, and TVALID stays 1.
  - Beat order is strictly preserved. No beat is dropped or duplicated.
  - While M_AXIS_TVALID=1 and M_AXIS_TREADY=0, M_AXIS_* stay stable (AXI rule).
- Reset mid-frame: all in-flight beats are discarded; the downstream block resynchronises on the next TUSER.

Test Plan:
1. Reset, then stream 4 beats with BYPASS_IN=0, MAP_IN=6'h21, TUSER on beat 0, and M_AXIS_TREADY held at 1. Input 24'hAABBCC → output 24'hAACCBB, one cycle later, back-to-back.
2. MAP_IN=6'h06 (out0=in2, out1=in1, out2=in0) presented with the SOF beat 24'h112233 → output 24'h332211. MAP_IN then changes to 6'h21 mid-frame: subsequent beats still use 6'h06 until the next TUSER beat, and MAP_ACTIVE stays 6'h06.
3. Backpressure: hold M_AXIS_TREADY=0 while 3 beats are offered. Exactly 2 beats are accepted and S_AXIS_TREADY=0. Release TREADY: the beats emerge in order with TUSER/TLAST intact, and no beat is duplicated.
4. Random TVALID/TREADY over 1000 beats with a scoreboard. Output sequence equals the permuted input sequence. M_AXIS_* are stable whenever stalled.
5. Out-of-range select: MAP_IN=6'h3F with BYPASS_IN=0 on SOF, input 24'hFFFFFF → output 24'h000000. Then BYPASS_IN=1 on the next SOF → output equals input.
6. Assert ARESET for one cycle with 2 beats buffered. TVALID goes to 0 immediately (async), MAP_ACTIVE returns to 6'h21, and no stale beat appears after reset.
